lsu_mem_master: RTL and testbench

- Load/store initiator that drives the word-wide DataMemory port (MemRead, MemWrite, addr, write_data, read_data) on behalf of the RV32I core.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Handles byte lanes and sign/zero extension; sub-word stores use read-modify-write.
- Sits between the execute stage and DataMemory, with a valid/ready request side and a one-cycle response pulse.

---
 rtl/lsu_mem_master.sv | 199 +++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator driving a word-wide DataMemory port.
// Loads and stores of any width become word accesses. Sub-word stores are done
// as read-modify-write. Misaligned or illegal requests are answered with an error
// and no memory strobe is issued.
// Optional build macro LSU_STATS_EN adds the completion counters ld_cnt, st_cnt
// and err_cnt.
//
// state | meaning
// IDLE  | accepting requests, strobes low
// RD    | MemRead high; MEM_RD_LAT extra cycles, then mem_rdata is sampled
// WR    | MemWrite high for exactly one cycle
// RSP   | rsp_valid pulse, req_ready low

module lsu_mem_master #(
  parameter int MEM_RD_LAT = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef LSU_STATS_EN
  output logic [15:0]       ld_cnt,
  output logic [15:0]       st_cnt,
  output logic [15:0]       err_cnt,
`endif
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam int CNT_W = (MEM_RD_LAT > 0) ? $clog2(MEM_RD_LAT + 1) : 1;

  state_t           state;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [15:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_illegal;
  logic [31:0]      load_word;
  logic [31:0]      merge_word;

  // Select the addressed lane and sign/zero extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Replace the addressed byte or halfword lane; other lanes come from memory.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                        input logic is_half, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (is_half) begin
      if (lane[1]) r[31:16] = d;
      else         r[15:0]  = d;
    end else begin
      case (lane)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        2'd3: r[31:24] = d[7:0];
        default: r = w;
      endcase
    end
    return r;
  endfunction

  // Classify the incoming request: bad funct3, signed-less store width, or misalignment.
  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      3'b001, 3'b101:         req_illegal = req_addr[0];
      3'b010:                 req_illegal = |req_addr[1:0];
      default:                req_illegal = 1'b0;
    endcase
    if (req_we && req_funct3[2]) req_illegal = 1'b1;
  end

  assign load_word  = extract(mem_rdata, lane_q, f3_q);
  assign merge_word = merge(mem_rdata, lane_q, f3_q[0], wdata_q);

  // Access sequencer with registered strobes and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (req_illegal) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && req_funct3 == 3'b010) begin
                state     <= WR;
                MemWrite  <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state    <= RD;
                MemRead  <= 1'b1;
                wait_cnt <= CNT_W'(MEM_RD_LAT);
              end
            end
          end
        end
        RD: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            MemRead <= 1'b0;
            if (we_q) begin
              state     <= WR;
              MemWrite  <= 1'b1;
              mem_wdata <= merge_word;
            end else begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_word;
            end
          end
        end
        WR: begin
          MemWrite  <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RSP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  // Count completions by type during the response cycle; counters wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt  <= '0;
      st_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == RSP) begin
      if (rsp_err)   err_cnt <= err_cnt + 16'd1;
      else if (we_q) st_cnt  <= st_cnt + 16'd1;
      else           ld_cnt  <= ld_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (MEM_RD_LAT 0 and 2), each with a
// small word memory and a transaction-level model that predicts every cycle
// of an access from the latency and lane rules.

module tb_lsu_mem_master;

  typedef struct {
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [5:0]  widx;
    bit        rv;
    bit        err;
    bit [31:0] rdata;
  } rec_t;

  logic clk, rst;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_err, MemRead, MemWrite;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int rd_cnt [2];
  int wr_cnt [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input int k, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int size_of(input bit [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_illegal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic bit [31:0] load_val(input bit [31:0] w, input bit [1:0] off, input bit [2:0] f3);
    bit [63:0] v;
    int bits;
    bits = 8 * size_of(f3);
    if (bits == 32) return w;
    v = {32'h0, w} >> (8 * off);
    v = v & ((64'd1 << bits) - 64'd1);
    if (!f3[2] && v[bits-1]) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic bit [31:0] store_merge(input bit [31:0] old, input bit [1:0] off,
                                            input bit [2:0] f3, input bit [31:0] d);
    bit [31:0] mask;
    if (size_of(f3) == 4) return d;
    mask = (size_of(f3) == 1) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (MemRead[k])  rd_cnt[k]++;
      if (MemWrite[k]) wr_cnt[k]++;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = 2 * g;
    bit [31:0] mem [64];
    bit [31:0] model_mem [64];
    rec_t      sched [$];
    bit [31:0] last_rdata;

    lsu_mem_master #(.MEM_RD_LAT(LAT), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .MemRead    (MemRead[g]),
      .MemWrite   (MemWrite[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );

    assign mem_rdata[g] = mem[mem_addr[g][7:2]];

    always @(posedge clk) if (MemWrite[g] === 1'b1) mem[mem_addr[g][7:2]] <= mem_wdata[g];

    always @(negedge clk) begin : cmp
      rec_t      r;
      rec_t      n;
      bit        idle;
      bit [31:0] a;
      bit [5:0]  idx;
      if (rst) begin
        sched.delete();
        last_rdata = '0;
        check1("rst_ready", g, req_ready[g], 1'b1);
        check1("rst_memread", g, MemRead[g], 1'b0);
        check1("rst_memwrite", g, MemWrite[g], 1'b0);
        check1("rst_rsp_valid", g, rsp_valid[g], 1'b0);
        check("rst_rsp_rdata", g, rsp_rdata[g], 32'h0);
      end else begin
        idle = (sched.size() == 0);
        r = '{default: '0};
        if (!idle) r = sched[0];
        check1("req_ready", g, req_ready[g], idle);
        check1("MemRead", g, MemRead[g], r.rd);
        check1("MemWrite", g, MemWrite[g], r.wr);
        check1("rsp_valid", g, rsp_valid[g], r.rv);
        if (r.rv) last_rdata = r.rdata;
        check("rsp_rdata", g, rsp_rdata[g], last_rdata);
        if (r.rv) check1("rsp_err", g, rsp_err[g], r.err);
        if (r.rd || r.wr) check("mem_addr", g, mem_addr[g], r.addr);
        if (r.wr) begin
          check("mem_wdata", g, mem_wdata[g], r.wdata);
          model_mem[r.widx] = r.wdata;
        end
        if (!idle) void'(sched.pop_front());
        if (idle && req_valid[g]) begin
          a   = req_addr[g];
          idx = a[7:2];
          n   = '{default: '0};
          if (is_illegal(req_we[g], req_funct3[g], a)) begin
            n.rv  = 1'b1;
            n.err = 1'b1;
            sched.push_back(n);
          end else begin
            if (!(req_we[g] && size_of(req_funct3[g]) == 4)) begin
              n.rd   = 1'b1;
              n.addr = a & 32'hFFFF_FFFC;
              repeat (LAT + 1) sched.push_back(n);
            end
            if (req_we[g]) begin
              n       = '{default: '0};
              n.wr    = 1'b1;
              n.addr  = a & 32'hFFFF_FFFC;
              n.widx  = idx;
              n.wdata = store_merge(model_mem[idx], a[1:0], req_funct3[g], req_wdata[g]);
              sched.push_back(n);
            end
            n    = '{default: '0};
            n.rv = 1'b1;
            if (!req_we[g]) n.rdata = load_val(model_mem[idx], a[1:0], req_funct3[g]);
            sched.push_back(n);
          end
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the response cycle.
  task automatic send(input int k, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                      input bit [31:0] wd, input bit hold,
                      output bit [31:0] rdata, output bit err, output int lat);
    int n;
    bit got;
    rdata = 32'hDEAD_BEEF;
    err   = 1'b1;
    lat   = -1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wd;
    req_valid[k]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[k] !== 1'b1 && n < 50);
    if (req_ready[k] !== 1'b1) begin
      check1("accept_timeout", k, req_ready[k], 1'b1);
      req_valid[k] = 1'b0;
      @(posedge clk); #2;
      return;
    end
    @(posedge clk); #2;
    if (!hold) req_valid[k] = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) begin
        got   = 1'b1;
        lat   = c;
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
      end
    end
    if (!got) check1("rsp_timeout", k, rsp_valid[k], 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic run_rand(input int k, input int cnt);
    bit [31:0] rd;
    bit        er;
    int        lt;
    bit        hold;
    bit [31:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      hold = (i < cnt - 1) && ($urandom_range(0, 2) == 0);
      send(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, hold, rd, er, lt);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #2;
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit [31:0] rd;
    bit        er;
    int        lt;
    int        r0, w0;
    rst        = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    #1;
    check1("reset_req_ready", 0, req_ready[0], 1'b1);
    check1("reset_memread", 0, MemRead[0], 1'b0);
    check("reset_mem_addr", 0, mem_addr[0], 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // SW then LW of the same word
    send(0, 1, 3'b010, 32'h8, 32'h0000_00C8, 0, rd, er, lt);
    check("sw_lat", 0, lt, 2);
    check1("sw_err", 0, er, 1'b0);
    check("sw_memword", 0, gen_dut[0].mem[2], 32'h0000_00C8);
    send(0, 0, 3'b010, 32'h8, 32'h0, 0, rd, er, lt);
    check("lw_rdata", 0, rd, 32'h0000_00C8);
    check("lw_lat", 0, lt, 2);

    // byte/half extraction
    send(0, 1, 3'b010, 32'h4, 32'h80FF_7F01, 0, rd, er, lt);
    send(0, 0, 3'b000, 32'h4, 32'h0, 0, rd, er, lt); check("lb_4", 0, rd, 32'h0000_0001);
    send(0, 0, 3'b000, 32'h5, 32'h0, 0, rd, er, lt); check("lb_5", 0, rd, 32'h0000_007F);
    send(0, 0, 3'b000, 32'h6, 32'h0, 0, rd, er, lt); check("lb_6", 0, rd, 32'hFFFF_FFFF);
    send(0, 0, 3'b100, 32'h7, 32'h0, 0, rd, er, lt); check("lbu_7", 0, rd, 32'h0000_0080);
    send(0, 0, 3'b001, 32'h6, 32'h0, 0, rd, er, lt); check("lh_6", 0, rd, 32'hFFFF_80FF);
    send(0, 0, 3'b101, 32'h6, 32'h0, 0, rd, er, lt); check("lhu_6", 0, rd, 32'h0000_80FF);

    // read-modify-write stores
    send(0, 1, 3'b010, 32'hC, 32'h1122_3344, 0, rd, er, lt);
    r0 = rd_cnt[0];
    w0 = wr_cnt[0];
    send(0, 1, 3'b000, 32'hD, 32'h0000_00AB, 0, rd, er, lt);
    check("sb_lat", 0, lt, 3);
    check("sb_rd_cycles", 0, rd_cnt[0] - r0, 1);
    check("sb_wr_cycles", 0, wr_cnt[0] - w0, 1);
    check("sb_memword", 0, gen_dut[0].mem[3], 32'h1122_AB44);
    send(0, 1, 3'b001, 32'hE, 32'h0000_BEEF, 0, rd, er, lt);
    send(0, 0, 3'b010, 32'hC, 32'h0, 0, rd, er, lt);
    check("sh_result", 0, rd, 32'hBEEF_AB44);

    // illegal accesses
    r0 = rd_cnt[0];
    w0 = wr_cnt[0];
    send(0, 0, 3'b010, 32'h6, 32'h0, 0, rd, er, lt);
    check1("lw6_err", 0, er, 1'b1); check("lw6_rdata", 0, rd, 32'h0); check("lw6_lat", 0, lt, 1);
    send(0, 1, 3'b001, 32'h3, 32'h1234, 0, rd, er, lt);
    check1("sh3_err", 0, er, 1'b1); check("sh3_rdata", 0, rd, 32'h0); check("sh3_lat", 0, lt, 1);
    send(0, 0, 3'b011, 32'h0, 32'h0, 0, rd, er, lt);
    check1("f011_err", 0, er, 1'b1); check("f011_lat", 0, lt, 1);
    check("err_no_strobes", 0, (rd_cnt[0] - r0) + (wr_cnt[0] - w0), 0);

    // reset during the read phase of an SB
    send(0, 1, 3'b010, 32'h10, 32'h5566_7788, 0, rd, er, lt);
    w0 = wr_cnt[0];
    req_we[0]     = 1'b1;
    req_funct3[0] = 3'b000;
    req_addr[0]   = 32'h10;
    req_wdata[0]  = 32'h99;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    check1("rmw_accept_ready", 0, req_ready[0], 1'b1);
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    check1("rmw_in_read", 0, MemRead[0], 1'b1);
    rst = 1'b1;
    #1;
    check1("rst_drops_memread", 0, MemRead[0], 1'b0);
    check1("rst_no_memwrite", 0, MemWrite[0], 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check1("post_rst_ready", 0, req_ready[0], 1'b1);
    check("rmw_abandoned_wr", 0, wr_cnt[0] - w0, 0);
    check("rmw_word_kept", 0, gen_dut[0].mem[4], 32'h5566_7788);
    @(posedge clk); #2;
    send(0, 0, 3'b010, 32'h10, 32'h0, 0, rd, er, lt);
    check("rmw_word_load", 0, rd, 32'h5566_7788);

    // MEM_RD_LAT = 2 instance
    send(1, 1, 3'b010, 32'h4, 32'h80FF_7F01, 0, rd, er, lt);
    check("lat2_sw_lat", 1, lt, 2);
    r0 = rd_cnt[1];
    send(1, 0, 3'b010, 32'h4, 32'h0, 0, rd, er, lt);
    check("lat2_lw_lat", 1, lt, 4);
    check("lat2_lw_rd_cycles", 1, rd_cnt[1] - r0, 3);
    check("lat2_lw_rdata", 1, rd, 32'h80FF_7F01);
    send(1, 1, 3'b000, 32'h5, 32'h12, 0, rd, er, lt);
    check("lat2_sb_lat", 1, lt, 5);
    send(1, 0, 3'b010, 32'h4, 32'h0, 1, rd, er, lt);
    send(1, 0, 3'b001, 32'h6, 32'h0, 0, rd, er, lt);
    check("lat2_b2b_lh", 1, rd, 32'hFFFF_80FF);

    fork
      run_rand(0, 200);
      run_rand(1, 150);
    join
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
